// File: rtl/spi_slave_cfg.sv
// SPI mode-0 configuration responder: oversamples SCK/CS_N/MOSI in the CLK domain, decodes 32-bit frames
// into control-register writes/reads and a req/ack port towards the neuron/synapse memories.
module spi_slave_cfg #(
  parameter int         ADDR_W       = 14,
  parameter int         DATA_W       = 16,
  parameter logic [7:0] MAX_NEUR_RST = 8'd10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              SPI_OPEN_LOOP,
  output logic              SPI_AER_SRC_CTRL_nNEUR,
  output logic [7:0]        SPI_MAX_NEUR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              SPI_ERR,
  output logic [1:0]        dbg_state
);

  localparam int HDR_W = 2 + ADDR_W;
  localparam int FW    = HDR_W + DATA_W;
  localparam int CNT_W = $clog2(FW + 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FW - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] CMD_REG_WR = 2'b00;
  localparam logic [1:0] CMD_REG_RD = 2'b01;
  localparam logic [1:0] CMD_MEM_WR = 2'b10;
  localparam logic [1:0] CMD_MEM_RD = 2'b11;

  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= SCK;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      cs_s1   <= CS_N;
      cs_s2   <= cs_s1;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sck_rise, sck_fall;
  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FW-2:0]     shift_in;
  logic [FW-1:0]     next_in;
  logic [DATA_W-1:0] out_sh;
  logic [DATA_W-1:0] out_src;
  logic [DATA_W-1:0] reg_rd_val;
  logic              rd_wait;
  logic              req_busy;
  logic              ack_load;

  // next_in is the frame including the bit arriving on this rise; fields are decoded from it
  assign next_in = {shift_in, mosi_s2};

  logic [1:0]        hdr_cmd;
  logic [ADDR_W-1:0] hdr_addr;
  logic [1:0]        frm_cmd;
  logic [ADDR_W-1:0] frm_addr;
  logic [DATA_W-1:0] frm_data;
  assign hdr_cmd  = next_in[HDR_W-1 -: 2];
  assign hdr_addr = next_in[ADDR_W-1:0];
  assign frm_cmd  = next_in[FW-1 -: 2];
  assign frm_addr = next_in[FW-3 -: ADDR_W];
  assign frm_data = next_in[DATA_W-1:0];

  // Memory port: MEM_REQ with ADDR/WE/WDATA held stable until the cycle MEM_ACK=1 is seen, then REQ drops.
  assign req_busy = MEM_REQ & ~MEM_ACK;
  assign ack_load = MEM_REQ & MEM_ACK & rd_wait;
  assign out_src  = ack_load ? MEM_RDATA : out_sh;

  always_comb begin
    reg_rd_val = '0;
    case (hdr_addr)
      ADDR_W'(0): reg_rd_val[0]   = SPI_OPEN_LOOP;
      ADDR_W'(1): reg_rd_val[0]   = SPI_AER_SRC_CTRL_nNEUR;
      ADDR_W'(2): reg_rd_val[7:0] = SPI_MAX_NEUR;
      ADDR_W'(3): reg_rd_val[0]   = SPI_ERR;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state                  <= ST_IDLE;
      bit_cnt                <= '0;
      shift_in               <= '0;
      out_sh                 <= '0;
      rd_wait                <= 1'b0;
      MISO                   <= 1'b0;
      SPI_OPEN_LOOP          <= 1'b1;
      SPI_AER_SRC_CTRL_nNEUR <= 1'b0;
      SPI_MAX_NEUR           <= MAX_NEUR_RST;
      MEM_REQ                <= 1'b0;
      MEM_WE                 <= 1'b0;
      MEM_ADDR               <= '0;
      MEM_WDATA              <= '0;
      SPI_ERR                <= 1'b0;
    end else begin
      if (MEM_REQ && MEM_ACK) MEM_REQ <= 1'b0;
      if (ack_load) begin
        out_sh  <= MEM_RDATA;
        rd_wait <= 1'b0;
      end
      if (cs_s2) begin
        // deselect aborts the frame; an outstanding request still completes on its ACK
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        shift_in <= '0;
        MISO     <= 1'b0;
        rd_wait  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_HDR;
            bit_cnt  <= '0;
            shift_in <= '0;
            MISO     <= 1'b0;
          end
          ST_HDR: begin
            MISO <= 1'b0;
            if (sck_rise) begin
              shift_in <= next_in[FW-2:0];
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == HDR_LAST) begin
                state  <= ST_DATA;
                out_sh <= '0;
                case (hdr_cmd)
                  CMD_REG_RD: out_sh <= reg_rd_val;
                  CMD_MEM_RD: begin
                    if (req_busy) begin
                      SPI_ERR <= 1'b1;
                    end else begin
                      MEM_REQ  <= 1'b1;
                      MEM_WE   <= 1'b0;
                      MEM_ADDR <= hdr_addr;
                      rd_wait  <= 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              shift_in <= next_in[FW-2:0];
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == FRM_LAST) begin
                state <= ST_DONE;
                MISO  <= 1'b0;
                case (frm_cmd)
                  CMD_REG_WR: begin
                    case (frm_addr)
                      ADDR_W'(0): SPI_OPEN_LOOP          <= frm_data[0];
                      ADDR_W'(1): SPI_AER_SRC_CTRL_nNEUR <= frm_data[0];
                      ADDR_W'(2): SPI_MAX_NEUR           <= frm_data[7:0];
                      ADDR_W'(3): SPI_ERR                <= 1'b0;
                      default: ;
                    endcase
                  end
                  CMD_MEM_WR: begin
                    if (req_busy) begin
                      SPI_ERR <= 1'b1;
                    end else begin
                      MEM_REQ   <= 1'b1;
                      MEM_WE    <= 1'b1;
                      MEM_ADDR  <= frm_addr;
                      MEM_WDATA <= frm_data;
                    end
                  end
                  default: ;
                endcase
              end
            end else if (sck_fall) begin
              // read data not back by the first data bit: send zeros and flag it; late ACK data is dropped
              if (rd_wait && !ack_load) begin
                SPI_ERR <= 1'b1;
                rd_wait <= 1'b0;
                out_sh  <= '0;
                MISO    <= 1'b0;
              end else begin
                MISO   <= out_src[DATA_W-1];
                out_sh <= {out_src[DATA_W-2:0], 1'b0};
              end
            end
          end
          ST_DONE: MISO <= 1'b0;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: directed scenarios plus random frames checked against a field-level model
// of the register file and a queue of expected memory requests.
module tb_spi_slave_cfg;
  localparam int HALF = 8;
  localparam int GAP  = 6;

  logic        CLK = 1'b0;
  logic        RST, SCK, CS_N, MOSI, MISO;
  logic        SPI_OPEN_LOOP, SPI_AER_SRC_CTRL_nNEUR, MEM_REQ, MEM_WE, MEM_ACK, SPI_ERR;
  logic [7:0]  SPI_MAX_NEUR;
  logic [13:0] MEM_ADDR;
  logic [15:0] MEM_WDATA, MEM_RDATA;
  logic [1:0]  dbg_state;

  spi_slave_cfg dut (
    .CLK(CLK), .RST(RST), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
    .SPI_OPEN_LOOP(SPI_OPEN_LOOP), .SPI_AER_SRC_CTRL_nNEUR(SPI_AER_SRC_CTRL_nNEUR),
    .SPI_MAX_NEUR(SPI_MAX_NEUR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .SPI_ERR(SPI_ERR),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic       m_open, m_aer, m_err;
  logic [7:0] m_max;
  bit         m_pend;
  logic [30:0] exp_q[$];
  logic [30:0] obs_q[$];

  // memory responder controls and observations
  bit          ack_enable = 1'b1;
  int          ack_delay = 2;
  logic [15:0] rdata_val = 16'h0;
  int          held = 0;
  int          last_held = 0;
  int          stab_err = 0;
  int          drop_err = 0;
  logic [30:0] cur_req;

  logic [7:0] snap_max;
  logic       snap_open, snap_aer;

  initial begin
    MEM_ACK = 1'b0;
    MEM_RDATA = 16'h0;
    forever begin
      @(negedge CLK);
      if (MEM_ACK) begin
        MEM_ACK = 1'b0;
        held = 0;
        if (MEM_REQ) drop_err++;
      end else if (MEM_REQ) begin
        if (held == 0) begin
          cur_req = {MEM_WE, MEM_ADDR, MEM_WDATA};
          obs_q.push_back(cur_req);
        end else if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== cur_req) begin
          stab_err++;
        end
        held++;
        if (ack_enable && held >= ack_delay) begin
          MEM_ACK = 1'b1;
          MEM_RDATA = rdata_val;
          last_held = held;
        end
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_open = 1'b1; m_aer = 1'b0; m_max = 8'd10; m_err = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_frame(input logic [31:0] f, output logic [31:0] exp_rx);
    logic [1:0]  cmd;
    logic [13:0] a;
    logic [15:0] d;
    cmd = f[31:30]; a = f[29:16]; d = f[15:0];
    exp_rx = 32'h0;
    case (cmd)
      2'b00: begin
        if (a == 14'd0) m_open = d[0];
        else if (a == 14'd1) m_aer = d[0];
        else if (a == 14'd2) m_max = d[7:0];
        else if (a == 14'd3) m_err = 1'b0;
      end
      2'b01: begin
        if (a == 14'd0) exp_rx = {31'h0, m_open};
        else if (a == 14'd1) exp_rx = {31'h0, m_aer};
        else if (a == 14'd2) exp_rx = {24'h0, m_max};
        else if (a == 14'd3) exp_rx = {31'h0, m_err};
      end
      2'b10: begin
        if (m_pend) m_err = 1'b1;
        else begin
          exp_q.push_back({1'b1, a, d});
          m_pend = !ack_enable;
        end
      end
      default: begin
        if (m_pend) m_err = 1'b1;
        else begin
          exp_q.push_back({1'b0, a, 16'h0});
          if (ack_enable && ack_delay <= 4) exp_rx = {16'h0, rdata_val};
          else m_err = 1'b1;
          m_pend = !ack_enable;
        end
      end
    endcase
  endtask

  task automatic spi_xfer(input logic [31:0] tx, input int nbits, input bit rst_mid, output logic [31:0] rx);
    rx = 32'h0;
    @(negedge CLK);
    CS_N = 1'b0;
    repeat (HALF) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 32) ? tx[31-i] : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge CLK);
      SCK = 1'b1;
      if (i < 32) rx = {rx[30:0], MISO};
      if (i == 31) begin
        repeat (3) @(posedge CLK);
        #1;
        snap_max = SPI_MAX_NEUR; snap_open = SPI_OPEN_LOOP; snap_aer = SPI_AER_SRC_CTRL_nNEUR;
        repeat (HALF - 2) @(negedge CLK);
      end else begin
        repeat (HALF) @(negedge CLK);
      end
      SCK = 1'b0;
    end
    if (rst_mid) begin
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
    end
    repeat (HALF) @(negedge CLK);
    CS_N = 1'b1;
    MOSI = 1'b0;
    repeat (GAP) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (SPI_MAX_NEUR !== 8'd10) begin failures++; $display("FAIL rst_in_max: got %0d want 10", SPI_MAX_NEUR); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    model_reset();
    checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL rst_miso: got %b want 0", MISO); end
    checks++; if (SPI_OPEN_LOOP !== 1'b1) begin failures++; $display("FAIL rst_open: got %b want 1", SPI_OPEN_LOOP); end
    checks++; if (SPI_AER_SRC_CTRL_nNEUR !== 1'b0) begin failures++; $display("FAIL rst_aer: got %b want 0", SPI_AER_SRC_CTRL_nNEUR); end
    checks++; if (SPI_MAX_NEUR !== 8'd10) begin failures++; $display("FAIL rst_max: got %0d want 10", SPI_MAX_NEUR); end
    checks++; if ({MEM_REQ, MEM_WE} !== 2'b00) begin failures++; $display("FAIL rst_req_we: got %b want 00", {MEM_REQ, MEM_WE}); end
    checks++; if ({MEM_ADDR, MEM_WDATA} !== 30'h0) begin failures++; $display("FAIL rst_addr_wdata: got %h want 0", {MEM_ADDR, MEM_WDATA}); end
    checks++; if (SPI_ERR !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", SPI_ERR); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_reg_read_defaults();
    logic [31:0] rx, er;
    logic [15:0] want[3];
    want[0] = 16'h0001; want[1] = 16'h0000; want[2] = 16'h000A;
    for (int a = 0; a < 3; a++) begin
      model_frame({2'b01, 14'(a), 16'h0}, er);
      spi_xfer({2'b01, 14'(a), 16'h0}, 32, 1'b0, rx);
      checks++; if (rx !== {16'h0, want[a]}) begin failures++; $display("FAIL rd_default addr%0d: got %h want %h", a, rx, {16'h0, want[a]}); end
    end
  endtask

  task automatic test_reg_write();
    logic [31:0] rx, er;
    model_frame({2'b00, 14'd2, 16'h00C8}, er);
    spi_xfer({2'b00, 14'd2, 16'h00C8}, 32, 1'b0, rx);
    checks++; if (snap_max !== 8'd200) begin failures++; $display("FAIL wr_max_3clk: got %0d want 200", snap_max); end
    checks++; if ({snap_open, snap_aer} !== 2'b10) begin failures++; $display("FAIL wr_other_regs: got %b want 10", {snap_open, snap_aer}); end
    checks++; if (SPI_ERR !== 1'b0) begin failures++; $display("FAIL wr_err: got %b want 0", SPI_ERR); end
    checks++; if (rx !== 32'h0) begin failures++; $display("FAIL wr_miso: got %h want 0", rx); end
  endtask

  task automatic test_mem_write();
    logic [31:0] rx, er;
    logic [30:0] o;
    ack_delay = 5; stab_err = 0; drop_err = 0;
    obs_q.delete(); exp_q.delete();
    model_frame({2'b10, 14'h2005, 16'hBEEF}, er);
    spi_xfer({2'b10, 14'h2005, 16'hBEEF}, 32, 1'b0, rx);
    repeat (10) @(negedge CLK);
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL memwr_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++; if (o !== {1'b1, 14'h2005, 16'hBEEF}) begin failures++; $display("FAIL memwr_fields: got %h want %h", o, {1'b1, 14'h2005, 16'hBEEF}); end
    end
    exp_q.delete();
    checks++; if (last_held != 5) begin failures++; $display("FAIL memwr_held: got %0d want 5", last_held); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL memwr_stable: got %0d want 0", stab_err); end
    checks++; if (drop_err != 0) begin failures++; $display("FAIL memwr_drop: got %0d want 0", drop_err); end
    checks++; if (MEM_REQ !== 1'b0) begin failures++; $display("FAIL memwr_req_end: got %b want 0", MEM_REQ); end
  endtask

  task automatic test_mem_read();
    logic [31:0] rx, er;
    logic [30:0] o;
    ack_delay = 2; rdata_val = 16'h1234; ack_enable = 1'b1;
    obs_q.delete(); exp_q.delete();
    model_frame({2'b11, 14'h0010, 16'h0}, er);
    spi_xfer({2'b11, 14'h0010, 16'h0}, 32, 1'b0, rx);
    checks++; if (rx !== 32'h0000_1234) begin failures++; $display("FAIL memrd_data: got %h want 00001234", rx); end
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL memrd_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++; if (o[30:16] !== {1'b0, 14'h0010}) begin failures++; $display("FAIL memrd_fields: got %h want 0010", o[30:16]); end
    end
    checks++; if (SPI_ERR !== 1'b0) begin failures++; $display("FAIL memrd_err: got %b want 0", SPI_ERR); end
    // withheld acknowledge
    ack_enable = 1'b0; rdata_val = 16'h5555;
    model_frame({2'b11, 14'h0010, 16'h0}, er);
    spi_xfer({2'b11, 14'h0010, 16'h0}, 32, 1'b0, rx);
    checks++; if (rx !== 32'h0) begin failures++; $display("FAIL memrd_late_data: got %h want 0", rx); end
    checks++; if (SPI_ERR !== 1'b1) begin failures++; $display("FAIL memrd_late_err: got %b want 1", SPI_ERR); end
    checks++; if (MEM_REQ !== 1'b1) begin failures++; $display("FAIL memrd_req_held: got %b want 1", MEM_REQ); end
    model_frame({2'b01, 14'd3, 16'h0}, er);
    spi_xfer({2'b01, 14'd3, 16'h0}, 32, 1'b0, rx);
    checks++; if (rx !== 32'h1) begin failures++; $display("FAIL reg3_rd_err: got %h want 1", rx); end
    ack_enable = 1'b1;
    for (int i = 0; i < 50 && MEM_REQ; i++) @(negedge CLK);
    m_pend = 1'b0;
    checks++; if (MEM_REQ !== 1'b0) begin failures++; $display("FAIL memrd_late_ack: got %b want 0", MEM_REQ); end
    model_frame({2'b00, 14'd3, 16'hFFFF}, er);
    spi_xfer({2'b00, 14'd3, 16'hFFFF}, 32, 1'b0, rx);
    checks++; if (SPI_ERR !== 1'b0) begin failures++; $display("FAIL reg3_clear: got %b want 0", SPI_ERR); end
    model_frame({2'b01, 14'd3, 16'h0}, er);
    spi_xfer({2'b01, 14'd3, 16'h0}, 32, 1'b0, rx);
    checks++; if (rx !== 32'h0) begin failures++; $display("FAIL reg3_rd_clear: got %h want 0", rx); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    logic [31:0] rx, er;
    obs_q.delete();
    spi_xfer({2'b10, 14'h0001, 16'h1234}, 20, 1'b0, rx);
    repeat (10) @(negedge CLK);
    checks++; if (obs_q.size() != 0 || MEM_REQ !== 1'b0) begin failures++; $display("FAIL abort_req: got %0d reqs, req=%b want 0", obs_q.size(), MEM_REQ); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL abort_state: got %0d want 0", dbg_state); end
    model_frame({2'b00, 14'd0, 16'h0000}, er);
    spi_xfer({2'b00, 14'd0, 16'h0000}, 32, 1'b0, rx);
    checks++; if (SPI_OPEN_LOOP !== 1'b0) begin failures++; $display("FAIL abort_next_frame: got %b want 0", SPI_OPEN_LOOP); end
  endtask

  task automatic test_extra_bits();
    logic [31:0] rx, er;
    model_frame({2'b00, 14'd1, 16'h0001}, er);
    spi_xfer({2'b00, 14'd1, 16'h0001}, 40, 1'b0, rx);
    checks++; if ({SPI_AER_SRC_CTRL_nNEUR, SPI_MAX_NEUR, SPI_OPEN_LOOP} !== {m_aer, m_max, m_open}) begin
      failures++; $display("FAIL extra_bits: got %h want %h", {SPI_AER_SRC_CTRL_nNEUR, SPI_MAX_NEUR, SPI_OPEN_LOOP}, {m_aer, m_max, m_open}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx, er;
    logic [30:0] o;
    obs_q.delete(); exp_q.delete();
    ack_enable = 1'b0;
    model_frame({2'b10, 14'h0100, 16'hA5A5}, er);
    spi_xfer({2'b10, 14'h0100, 16'hA5A5}, 32, 1'b0, rx);
    model_frame({2'b10, 14'h0200, 16'h5A5A}, er);
    spi_xfer({2'b10, 14'h0200, 16'h5A5A}, 32, 1'b0, rx);
    checks++; if (SPI_ERR !== m_err) begin failures++; $display("FAIL b2b_err: got %b want %b", SPI_ERR, m_err); end
    checks++; if ({MEM_REQ, MEM_ADDR, MEM_WDATA} !== {1'b1, 14'h0100, 16'hA5A5}) begin
      failures++; $display("FAIL b2b_held: got %h want %h", {MEM_REQ, MEM_ADDR, MEM_WDATA}, {1'b1, 14'h0100, 16'hA5A5}); end
    ack_enable = 1'b1;
    for (int i = 0; i < 50 && MEM_REQ; i++) @(negedge CLK);
    m_pend = 1'b0;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++; if (o !== exp_q[0]) begin failures++; $display("FAIL b2b_fields: got %h want %h", o, exp_q[0]); end
    end
    obs_q.delete(); exp_q.delete();
    model_frame({2'b00, 14'd3, 16'h0}, er);
    spi_xfer({2'b00, 14'd3, 16'h0}, 32, 1'b0, rx);
    checks++; if (SPI_ERR !== 1'b0) begin failures++; $display("FAIL b2b_clear: got %b want 0", SPI_ERR); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx, er;
    spi_xfer({2'b10, 14'h0033, 16'h7777}, 10, 1'b1, rx);
    model_reset();
    repeat (10) @(negedge CLK);
    checks++; if ({SPI_OPEN_LOOP, SPI_AER_SRC_CTRL_nNEUR} !== 2'b10) begin failures++; $display("FAIL midrst_ctrl: got %b want 10", {SPI_OPEN_LOOP, SPI_AER_SRC_CTRL_nNEUR}); end
    checks++; if (SPI_MAX_NEUR !== 8'd10) begin failures++; $display("FAIL midrst_max: got %0d want 10", SPI_MAX_NEUR); end
    checks++; if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA} !== 32'h0) begin failures++; $display("FAIL midrst_mem: got %h want 0", {MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA}); end
    checks++; if ({MISO, SPI_ERR} !== 2'b00) begin failures++; $display("FAIL midrst_miso_err: got %b want 00", {MISO, SPI_ERR}); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    model_frame({2'b00, 14'd2, 16'h0033}, er);
    spi_xfer({2'b00, 14'd2, 16'h0033}, 32, 1'b0, rx);
    checks++; if (SPI_MAX_NEUR !== 8'h33) begin failures++; $display("FAIL midrst_next_wr: got %h want 33", SPI_MAX_NEUR); end
    model_frame({2'b01, 14'd2, 16'h0}, er);
    spi_xfer({2'b01, 14'd2, 16'h0}, 32, 1'b0, rx);
    checks++; if (rx !== er) begin failures++; $display("FAIL midrst_next_rd: got %h want %h", rx, er); end
  endtask

  task automatic test_random();
    logic [31:0] f, rx, er;
    logic [30:0] e, o;
    logic [1:0]  cmd;
    logic [13:0] a;
    obs_q.delete(); exp_q.delete();
    ack_enable = 1'b1;
    for (int n = 0; n < 24; n++) begin
      cmd = 2'($urandom_range(0, 3));
      if (cmd[1] || $urandom_range(0, 3) == 0) a = 14'($urandom);
      else a = 14'($urandom_range(0, 4));
      f = {cmd, a, 16'($urandom)};
      ack_delay = $urandom_range(1, 4);
      rdata_val = 16'($urandom);
      model_frame(f, er);
      spi_xfer(f, 32, 1'b0, rx);
      repeat (8) @(negedge CLK);
      checks++; if (rx !== er) begin failures++; $display("FAIL rnd_miso frame %0d (%h): got %h want %h", n, f, rx, er); end
      checks++; if ({SPI_OPEN_LOOP, SPI_AER_SRC_CTRL_nNEUR, SPI_MAX_NEUR} !== {m_open, m_aer, m_max}) begin
        failures++; $display("FAIL rnd_regs frame %0d: got %h want %h", n, {SPI_OPEN_LOOP, SPI_AER_SRC_CTRL_nNEUR, SPI_MAX_NEUR}, {m_open, m_aer, m_max}); end
      checks++; if (SPI_ERR !== m_err) begin failures++; $display("FAIL rnd_err frame %0d: got %b want %b", n, SPI_ERR, m_err); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rnd_req_count frame %0d: got %0d want %0d", n, obs_q.size(), exp_q.size());
        obs_q.delete(); exp_q.delete();
      end else begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          if (!e[30]) o[15:0] = 16'h0;
          checks++; if (o !== e) begin failures++; $display("FAIL rnd_req frame %0d: got %h want %h", n, o, e); end
        end
      end
    end
    checks++; if (stab_err != 0 || drop_err != 0) begin failures++; $display("FAIL rnd_handshake: got stab=%0d drop=%0d want 0", stab_err, drop_err); end
  endtask

  initial begin
    test_reset();
    test_reg_read_defaults();
    test_reg_write();
    test_mem_write();
    test_mem_read();
    test_abort();
    test_extra_bits();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
